pkt_rx_checker: RTL and testbench

Receive-side endpoint for the WRR FIFO packet interface. It sits on the FIFO read port and consumes the byte stream (sop/eop/data, priority, declared length) that the FIFO emits. It checks framing, declared length, priority stability and the stimulus data pattern, keeps per-priority packet counters, and applies a fixed post-packet backpressure gap. It is the bench/on-chip counterpart of the packet stimulus generator driving the FIFO write port.

---
 rtl/pkt_if_pkg.sv | 25 ++
 rtl/pkt_rx_checker_if.sv | 25 ++
 rtl/pkt_prio_counters.sv | 33 +++
 rtl/pkt_rx_checker.sv | 164 ++++++++++++++++
 tb/tb_pkt_rx_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_if_pkg.sv
// Shared definitions for the packet receive checker.
// Default field widths, error-flag bit positions and the receive FSM encoding.
package pkt_if_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_PRIORITY_BIT = 3;
  localparam int unsigned DEF_DATA_NUMBIT  = 7;
  localparam int unsigned DEF_STEP         = 2;
  localparam int unsigned DEF_BP_GAP       = 2;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  // err_flags bit positions
  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_LEN   = 1;
  localparam int unsigned ERR_ORDER = 2;
  localparam int unsigned ERR_PRIO  = 3;
  localparam int unsigned NUM_ERR   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBody = 2'd1,
    StGap  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pkt_rx_checker_if.sv
// FIFO read-port bundle: beat valid/framing/payload/priority/length from the
// FIFO (master) and ready back from the consumer (slave).
interface pkt_rx_checker_if #(
  parameter int unsigned DATA_WIDTH   = pkt_if_pkg::DEF_DATA_WIDTH,
  parameter int unsigned PRIORITY_BIT = pkt_if_pkg::DEF_PRIORITY_BIT,
  parameter int unsigned DATA_NUMBIT  = pkt_if_pkg::DEF_DATA_NUMBIT
);
  logic                    rd_vld;
  logic                    rd_sop;
  logic                    rd_eop;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [PRIORITY_BIT-1:0] rd_prior;
  logic [DATA_NUMBIT-1:0]  rd_len;
  logic                    rd_ready;

  modport master (
    output rd_vld, rd_sop, rd_eop, rd_data, rd_prior, rd_len,
    input  rd_ready
  );

  modport slave (
    input  rd_vld, rd_sop, rd_eop, rd_data, rd_prior, rd_len,
    output rd_ready
  );
endinterface

// File: rtl/pkt_prio_counters.sv
// Bank of 2^PRIORITY_BIT saturating packet counters.
// Ports: clk, rst_n (async, active-low), clr (sync zero of all counters, wins
// over inc), inc + idx (bump counter idx by one), cnt (flat, counter p at
// [p*CNT_WIDTH +: CNT_WIDTH]).
module pkt_prio_counters #(
  parameter int unsigned PRIORITY_BIT = 3,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clr,
  input  logic                                   inc,
  input  logic [PRIORITY_BIT-1:0]                idx,
  output logic [CNT_WIDTH*(1<<PRIORITY_BIT)-1:0] cnt
);
  localparam int unsigned NumPrio = 1 << PRIORITY_BIT;

  for (genvar p = 0; p < NumPrio; p++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (inc && (idx == PRIORITY_BIT'(p)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end

    assign cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
endmodule

// File: rtl/pkt_rx_checker.sv
// Receive-side packet checker on the FIFO read port.
// Checks framing (sop/eop order), declared length, priority stability and the
// incrementing data pattern; counts completed packets per priority and holds
// rd_ready low for BP_GAP cycles after each packet.
// Ports: clk, rst_n (async, active-low), rd (read-port bundle, slave side),
// clr (sync clear of counters/sticky errors), pkt_done/pkt_prior/pkt_len
// (completion report), err_flags (sticky {prio,order,len,data}), err_pulse
// (any error event last cycle), pkt_cnt (flat per-priority counters).
module pkt_rx_checker
  import pkt_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned PRIORITY_BIT = DEF_PRIORITY_BIT,
  parameter int unsigned DATA_NUMBIT  = DEF_DATA_NUMBIT,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned BP_GAP       = DEF_BP_GAP,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  pkt_rx_checker_if.slave                        rd,
  input  logic                                   clr,
  output logic                                   pkt_done,
  output logic [PRIORITY_BIT-1:0]                pkt_prior,
  output logic [DATA_NUMBIT-1:0]                 pkt_len,
  output logic [NUM_ERR-1:0]                     err_flags,
  output logic                                   err_pulse,
  output logic [CNT_WIDTH*(1<<PRIORITY_BIT)-1:0] pkt_cnt
);
  localparam int unsigned GapW = (BP_GAP < 2) ? 1 : $clog2(BP_GAP + 1);

  rx_state_e               state_q, state_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic [DATA_NUMBIT-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [DATA_NUMBIT-1:0]  len_q, len_d;
  logic [PRIORITY_BIT-1:0] prio_q, prio_d;
  logic                    ready_q;
  logic                    done_q;
  logic [PRIORITY_BIT-1:0] pkt_prior_q;
  logic [DATA_NUMBIT-1:0]  pkt_len_q;
  logic [NUM_ERR-1:0]      err_flags_q, err_ev;
  logic                    err_pulse_q;

  logic                    acc;
  logic                    done;
  logic [DATA_NUMBIT-1:0]  done_len;
  logic [PRIORITY_BIT-1:0] done_prio;

  assign acc     = rd.rd_vld && ready_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DATA_NUMBIT'(1);

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    len_d     = len_q;
    prio_d    = prio_q;
    done      = 1'b0;
    done_len  = cnt_q;
    done_prio = prio_q;
    err_ev    = '0;

    case (state_q)
      StIdle, StBody: begin
        if (acc) begin
          if (rd.rd_sop) begin
            // A sop inside a packet abandons it and restarts as a fresh packet.
            if (state_q == StBody) err_ev[ERR_ORDER] = 1'b1;
            len_d  = rd.rd_len;
            prio_d = rd.rd_prior;
            exp_d  = rd.rd_data + DATA_WIDTH'(STEP);
            cnt_d  = DATA_NUMBIT'(1);
            if (rd.rd_eop) begin
              done              = 1'b1;
              done_len          = DATA_NUMBIT'(1);
              done_prio         = rd.rd_prior;
              err_ev[ERR_LEN]   = (rd.rd_len != DATA_NUMBIT'(1));
            end else begin
              state_d = StBody;
            end
          end else if (state_q == StIdle) begin
            err_ev[ERR_ORDER] = 1'b1;
          end else begin
            err_ev[ERR_DATA] = (rd.rd_data != exp_q);
            err_ev[ERR_PRIO] = (rd.rd_prior != prio_q);
            // Resync on the received byte so one bad byte reports once.
            exp_d = rd.rd_data + DATA_WIDTH'(STEP);
            cnt_d = cnt_inc;
            if (rd.rd_eop) begin
              done            = 1'b1;
              done_len        = cnt_inc;
              done_prio       = prio_q;
              err_ev[ERR_LEN] = (cnt_inc != len_q);
            end
          end

          if (done) begin
            state_d = (BP_GAP > 0) ? StGap : StIdle;
            gap_d   = GapW'(BP_GAP);
          end
        end
      end
      StGap: begin
        if (gap_q <= GapW'(1)) state_d = StIdle;
        else                   gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      len_q       <= '0;
      prio_q      <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      pkt_prior_q <= '0;
      pkt_len_q   <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      len_q       <= len_d;
      prio_q      <= prio_d;
      ready_q     <= (state_d != StGap);
      done_q      <= done;
      if (done) begin
        pkt_prior_q <= done_prio;
        pkt_len_q   <= done_len;
      end
      // Errors raised in the clear cycle survive the clear.
      err_flags_q <= clr ? err_ev : (err_flags_q | err_ev);
      err_pulse_q <= |err_ev;
    end
  end

  pkt_prio_counters #(
    .PRIORITY_BIT(PRIORITY_BIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_counters (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (done),
    .idx  (done_prio),
    .cnt  (pkt_cnt)
  );

  assign rd.rd_ready = ready_q;
  assign pkt_done    = done_q;
  assign pkt_prior   = pkt_prior_q;
  assign pkt_len     = pkt_len_q;
  assign err_flags   = err_flags_q;
  assign err_pulse   = err_pulse_q;
endmodule

// File: tb/tb_pkt_rx_checker.sv
// Randomized plus directed bench for pkt_rx_checker with a packet-level
// reference model; a second instance with BP_GAP=0 covers back-to-back flow.
module tb_pkt_rx_checker;
  import pkt_if_pkg::*;

  localparam int unsigned GAPV  = 2;
  localparam int unsigned STEPV = 2;
  localparam int unsigned NP    = 8;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic [2:0] prior;
    logic [6:0] len;
    logic       clr;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr1 = 1'b0;
  always #5 clk = ~clk;

  pkt_rx_checker_if rd ();
  pkt_rx_checker_if rd1 ();

  logic         pkt_done, pkt_done1;
  logic [2:0]   pkt_prior, pkt_prior1;
  logic [6:0]   pkt_len, pkt_len1;
  logic [3:0]   err_flags, err_flags1;
  logic         err_pulse, err_pulse1;
  logic [127:0] pkt_cnt, pkt_cnt1;

  pkt_rx_checker #(.BP_GAP(GAPV)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .clr(clr),
    .pkt_done(pkt_done), .pkt_prior(pkt_prior), .pkt_len(pkt_len),
    .err_flags(err_flags), .err_pulse(err_pulse), .pkt_cnt(pkt_cnt)
  );

  pkt_rx_checker #(.BP_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd(rd1), .clr(clr1),
    .pkt_done(pkt_done1), .pkt_prior(pkt_prior1), .pkt_len(pkt_len1),
    .err_flags(err_flags1), .err_pulse(err_pulse1), .pkt_cnt(pkt_cnt1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference model
  bit       m_in_pkt;
  int       m_q[$];
  int       m_prio, m_decl, m_gap;
  bit       e_ready, e_done, e_pulse;
  int       e_prior, e_len;
  logic [3:0] e_flags;
  int       e_cnt[NP];

  // Observed-behaviour trackers used by the literal pins
  int pulse_cnt = 0;
  int low_run = 0;
  int last_low_run = 0;

  beat_t bq[$];

  task automatic model_reset();
    m_in_pkt = 0; m_q.delete(); m_prio = 0; m_decl = 0; m_gap = 0;
    e_ready = 1; e_done = 0; e_pulse = 0; e_prior = 0; e_len = 0; e_flags = '0;
    for (int p = 0; p < NP; p++) e_cnt[p] = 0;
  endtask

  task automatic model_step(input bit vld, input beat_t b, input bit c, output bit acc);
    logic [3:0] ev;
    bit used, done;
    int rlen;
    ev = '0; used = 0; done = 0;
    acc = vld && e_ready;
    if (acc) begin
      if (b.sop) begin
        if (m_in_pkt) ev[ERR_ORDER] = 1'b1;
        m_q.delete();
        m_q.push_back(int'(b.data));
        m_prio = int'(b.prior); m_decl = int'(b.len); m_in_pkt = 1; used = 1;
      end else if (!m_in_pkt) begin
        ev[ERR_ORDER] = 1'b1;
      end else begin
        if (int'(b.data) != ((m_q[$] + STEPV) % 256)) ev[ERR_DATA] = 1'b1;
        if (int'(b.prior) != m_prio) ev[ERR_PRIO] = 1'b1;
        m_q.push_back(int'(b.data));
        used = 1;
      end
      if (used && b.eop) begin
        rlen = (m_q.size() > 127) ? 127 : m_q.size();
        if (rlen != m_decl) ev[ERR_LEN] = 1'b1;
        done = 1; e_prior = m_prio; e_len = rlen; m_in_pkt = 0;
        if (!c && e_cnt[m_prio] < 65535) e_cnt[m_prio]++;
      end
    end
    if (done) begin
      m_gap = GAPV; e_ready = (GAPV == 0);
    end else if (!e_ready) begin
      m_gap--; e_ready = (m_gap == 0);
    end
    if (c) begin
      for (int p = 0; p < NP; p++) e_cnt[p] = 0;
      e_flags = ev;
    end else begin
      e_flags = e_flags | ev;
    end
    e_done = done;
    e_pulse = (ev != 0);
  endtask

  function automatic logic [127:0] e_cnt_flat();
    logic [127:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*16 +: 16] = e_cnt[p][15:0];
    return v;
  endfunction

  task automatic compare();
    chk("rd_ready", rd.rd_ready, e_ready);
    chk("pkt_done", pkt_done, e_done);
    chk("pkt_prior", pkt_prior, e_prior);
    chk("pkt_len", pkt_len, e_len);
    chk("err_flags", err_flags, e_flags);
    chk("err_pulse", err_pulse, e_pulse);
    chk("pkt_cnt", pkt_cnt, e_cnt_flat());
    if (err_pulse) pulse_cnt++;
    if (!rd.rd_ready) low_run++;
    else begin
      if (low_run > 0) last_low_run = low_run;
      low_run = 0;
    end
  endtask

  task automatic step(input bit vld, input beat_t b, input bit c, output bit acc);
    rd.rd_vld = vld; rd.rd_sop = b.sop; rd.rd_eop = b.eop; rd.rd_data = b.data;
    rd.rd_prior = b.prior; rd.rd_len = b.len; clr = c;
    model_step(vld, b, c, acc);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    beat_t z;
    bit acc;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, acc);
  endtask

  task automatic do_clr();
    beat_t z;
    bit acc;
    z = '0;
    step(1'b0, z, 1'b1, acc);
  endtask

  task automatic do_reset();
    rd.rd_vld = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  // Queue one packet; bad_idx offsets that byte by +1, flip_idx switches priority
  task automatic gen_pkt(input int n, input int prio, input int decl, input int start,
                         input int bad_idx, input int flip_idx, input int flip_to,
                         input bit with_eop, input bit clr_on_eop);
    beat_t b;
    int d;
    d = start;
    for (int i = 0; i < n; i++) begin
      if (i == bad_idx) d = d + 1;
      b.sop   = (i == 0);
      b.eop   = with_eop && (i == n - 1);
      b.data  = 8'(d);
      b.prior = 3'((flip_idx >= 0 && i >= flip_idx) ? flip_to : prio);
      b.len   = 7'(decl);
      b.clr   = clr_on_eop && (i == n - 1);
      bq.push_back(b);
      d = (d + STEPV) % 256;
    end
  endtask

  task automatic run_queue(input int vld_pct, input int clr_pm, input int max_acc);
    int guard, nacc;
    bit acc, v, c;
    beat_t b;
    guard = 0; nacc = 0;
    while (bq.size() > 0 && nacc < max_acc) begin
      v = ($urandom_range(99) < vld_pct);
      b = bq[0];
      c = b.clr || ($urandom_range(999) < clr_pm);
      step(v, b, c, acc);
      if (acc) begin
        void'(bq.pop_front());
        nacc++;
      end
      guard++;
      if (guard > 20000) begin
        n_vec++; n_err++;
        $display("FAIL run_queue: got no drain expected drain within 20000 cycles");
        bq.delete();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    beat_t sb;
    int n, dl, bi, fi;
    rd.rd_vld = 0; rd.rd_sop = 0; rd.rd_eop = 0; rd.rd_data = '0; rd.rd_prior = '0;
    rd.rd_len = '0;
    rd1.rd_vld = 0; rd1.rd_sop = 0; rd1.rd_eop = 0; rd1.rd_data = '0; rd1.rd_prior = '0;
    rd1.rd_len = '0;
    model_reset();
    @(negedge clk);
    compare();
    do_reset();
    idle(2);

    // 16-byte packet, priority 3
    gen_pkt(16, 3, 16, 0, -1, -1, 0, 1, 0);
    run_queue(100, 0, 1000);
    idle(4);
    chk("pin_t1_len", pkt_len, 16);
    chk("pin_t1_cnt3", pkt_cnt[3*16 +: 16], 1);
    chk("pin_t1_flags", err_flags, 4'b0000);
    chk("pin_t1_gap", last_low_run, GAPV);

    // single-beat packets
    gen_pkt(1, 0, 1, 8'h40, -1, -1, 0, 1, 0);
    run_queue(100, 0, 1000);
    idle(3);
    chk("pin_t2_cnt0", pkt_cnt[0 +: 16], 1);
    chk("pin_t2_flags", err_flags, 4'b0000);
    pulse_cnt = 0;
    gen_pkt(1, 0, 2, 8'h40, -1, -1, 0, 1, 0);
    run_queue(100, 0, 1000);
    idle(3);
    chk("pin_t2_lenerr", err_flags, 4'b0010);
    chk("pin_t2_pulses", pulse_cnt, 1);

    // bad byte 5 with resync
    do_clr();
    pulse_cnt = 0;
    gen_pkt(16, 2, 16, 8'h10, 4, -1, 0, 1, 0);
    run_queue(100, 0, 1000);
    idle(4);
    chk("pin_t3_flags", err_flags, 4'b0001);
    chk("pin_t3_pulses", pulse_cnt, 1);

    // stray beat in idle, then sop inside a packet
    do_clr();
    sb = '0; sb.data = 8'h33;
    bq.push_back(sb);
    run_queue(100, 0, 1000);
    idle(1);
    chk("pin_t4_stray", err_flags, 4'b0100);
    do_clr();
    gen_pkt(5, 2, 8, 8'h00, -1, -1, 0, 0, 0);
    gen_pkt(4, 1, 4, 8'h80, -1, -1, 0, 1, 0);
    run_queue(100, 0, 1000);
    idle(4);
    chk("pin_t4_order", err_flags, 4'b0100);
    chk("pin_t4_cnt1", pkt_cnt[1*16 +: 16], 1);
    chk("pin_t4_cnt2", pkt_cnt[2*16 +: 16], 0);

    // priority change 3 -> 5 mid-packet
    do_clr();
    gen_pkt(6, 3, 6, 8'h20, -1, 3, 5, 1, 0);
    run_queue(100, 0, 1000);
    idle(4);
    chk("pin_t5_flags", err_flags, 4'b1000);
    chk("pin_t5_cnt3", pkt_cnt[3*16 +: 16], 1);
    chk("pin_t5_cnt5", pkt_cnt[5*16 +: 16], 0);
    chk("pin_t5_prior", pkt_prior, 3);

    // clr coinciding with completion and a length error
    do_clr();
    gen_pkt(3, 4, 3, 8'h00, -1, -1, 0, 1, 0);
    gen_pkt(3, 4, 5, 8'h00, -1, -1, 0, 1, 1);
    run_queue(100, 0, 1000);
    idle(4);
    chk("pin_t6_cnt", pkt_cnt, 128'd0);
    chk("pin_t6_flags", err_flags, 4'b0010);

    // randomized traffic
    do_clr();
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(99);
      if (r < 5) begin
        sb = '0; sb.data = 8'($urandom_range(255)); sb.eop = 1'($urandom_range(1));
        bq.push_back(sb);
      end else if (r < 10) begin
        gen_pkt($urandom_range(6, 2), $urandom_range(7), 5, $urandom_range(255), -1, -1, 0,
                0, 0);
      end else begin
        n  = $urandom_range(20, 1);
        dl = ($urandom_range(7) == 0) ? $urandom_range(127) : n;
        bi = ($urandom_range(9) == 0) ? $urandom_range(n - 1) : -1;
        fi = ($urandom_range(9) == 0) ? $urandom_range(n - 1) : -1;
        gen_pkt(n, $urandom_range(7), dl, $urandom_range(255), bi, fi, $urandom_range(7), 1, 0);
      end
    end
    run_queue(75, 20, 100000);
    idle(4);

    // reset in the middle of a packet, then clean traffic
    gen_pkt(10, 6, 10, 8'h05, -1, -1, 0, 1, 0);
    run_queue(100, 0, 4);
    bq.delete();
    do_reset();
    gen_pkt(5, 6, 5, 8'h05, -1, -1, 0, 1, 0);
    run_queue(80, 0, 1000);
    idle(4);
    chk("pin_rst_cnt6", pkt_cnt[6*16 +: 16], 1);
    chk("pin_rst_flags", err_flags, 4'b0000);

    // BP_GAP=0 instance: two back-to-back packets
    for (int i = 0; i < 6; i++) begin
      chk("gap0_ready", rd1.rd_ready, 1'b1);
      rd1.rd_vld   = 1'b1;
      rd1.rd_sop   = (i % 3 == 0);
      rd1.rd_eop   = (i % 3 == 2);
      rd1.rd_data  = 8'(10 + 2 * (i % 3));
      rd1.rd_prior = 3'd6;
      rd1.rd_len   = 7'd3;
      @(negedge clk);
    end
    rd1.rd_vld = 1'b0;
    chk("gap0_ready_end", rd1.rd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("gap0_cnt6", pkt_cnt1[6*16 +: 16], 2);
    chk("gap0_flags", err_flags1, 4'b0000);
    chk("gap0_len", pkt_len1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
